// File: rtl/char_pkg.sv
// Shared character-state definitions used by the state handler, position handler and renderer.
// Holds state codes, the state width and the default attack-phase frame lengths.
package char_pkg;

    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE              = 4'd0;
    localparam state_t S_LEFT              = 4'd1;
    localparam state_t S_RIGHT             = 4'd2;
    localparam state_t S_ATTACK_START      = 4'd3;
    localparam state_t S_ATTACK_ACTIVE     = 4'd4;
    localparam state_t S_ATTACK_RECOVERY   = 4'd5;
    localparam state_t S_ATTACK_DIR_START  = 4'd6;
    localparam state_t S_ATTACK_DIR_ACTIVE = 4'd7;
    localparam state_t S_ATTACK_DIR_RECOV  = 4'd8;

    localparam int ATK_START_FR_DEF  = 5;
    localparam int ATK_ACTIVE_FR_DEF = 2;
    localparam int ATK_RECOV_FR_DEF  = 16;
    localparam int DIR_START_FR_DEF  = 4;
    localparam int DIR_ACTIVE_FR_DEF = 3;
    localparam int DIR_RECOV_FR_DEF  = 15;

    function automatic logic is_attack_state(input state_t s);
        return (s >= S_ATTACK_START) && (s <= S_ATTACK_DIR_RECOV);
    endfunction

    // Movement-group decision; rule order matters (attack beats direction).
    function automatic state_t move_next(input logic left, input logic right,
                                         input logic press);
        state_t s;
        if (press && (left ^ right))  s = S_ATTACK_DIR_START;
        else if (press)               s = S_ATTACK_START;
        else if (left && !right)      s = S_LEFT;
        else if (right && !left)      s = S_RIGHT;
        else                          s = S_IDLE;
        return s;
    endfunction

endpackage

// File: rtl/char_state_handler.sv
// Per-player character state machine: movement from button levels, attacks sequenced
// through frame-counted startup/active/recovery phases. Advances only on frame_tick.
module char_state_handler
    import char_pkg::*;
#(
    parameter int ATK_START_FR  = ATK_START_FR_DEF,
    parameter int ATK_ACTIVE_FR = ATK_ACTIVE_FR_DEF,
    parameter int ATK_RECOV_FR  = ATK_RECOV_FR_DEF,
    parameter int DIR_START_FR  = DIR_START_FR_DEF,
    parameter int DIR_ACTIVE_FR = DIR_ACTIVE_FR_DEF,
    parameter int DIR_RECOV_FR  = DIR_RECOV_FR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_attack,
    output logic [STATE_W-1:0] state,
    output logic               hitbox_active,
    output logic               attack_busy
);

    // The phase counter is 5 bits, so every length must fit in 1..31.
    if (ATK_START_FR < 1 || ATK_START_FR > 31 || ATK_ACTIVE_FR < 1 || ATK_ACTIVE_FR > 31 ||
        ATK_RECOV_FR < 1 || ATK_RECOV_FR > 31 || DIR_START_FR < 1 || DIR_START_FR > 31 ||
        DIR_ACTIVE_FR < 1 || DIR_ACTIVE_FR > 31 || DIR_RECOV_FR < 1 || DIR_RECOV_FR > 31)
    begin : g_bad_frame_len
        $error("char_state_handler: frame lengths must be in 1..31");
    end

    localparam logic [4:0] L_AS = 5'(ATK_START_FR);
    localparam logic [4:0] L_AA = 5'(ATK_ACTIVE_FR);
    localparam logic [4:0] L_AR = 5'(ATK_RECOV_FR);
    localparam logic [4:0] L_DS = 5'(DIR_START_FR);
    localparam logic [4:0] L_DA = 5'(DIR_ACTIVE_FR);
    localparam logic [4:0] L_DR = 5'(DIR_RECOV_FR);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       atk_prev_q, atk_prev_d;
    logic       attack_press;
    state_t     move_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            atk_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            atk_prev_q <= atk_prev_d;
        end
    end

    assign attack_press = btn_attack & ~atk_prev_q;
    assign move_state   = move_next(btn_left, btn_right, attack_press);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        atk_prev_d = atk_prev_q;
        if (frame_tick) begin
            atk_prev_d = btn_attack;
            case (state_q)
                S_IDLE, S_LEFT, S_RIGHT: begin
                    state_d = move_state;
                    cnt_d   = is_attack_state(move_state) ? 5'd1 : 5'd0;
                end
                S_ATTACK_START: begin
                    if (cnt_q == L_AS) begin
                        state_d = S_ATTACK_ACTIVE;
                        cnt_d   = 5'd1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_ATTACK_ACTIVE: begin
                    if (cnt_q == L_AA) begin
                        state_d = S_ATTACK_RECOVERY;
                        cnt_d   = 5'd1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_ATTACK_DIR_START: begin
                    if (cnt_q == L_DS) begin
                        state_d = S_ATTACK_DIR_ACTIVE;
                        cnt_d   = 5'd1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_ATTACK_DIR_ACTIVE: begin
                    if (cnt_q == L_DA) begin
                        state_d = S_ATTACK_DIR_RECOV;
                        cnt_d   = 5'd1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                // Leaving recovery re-enters the movement group on the same tick.
                S_ATTACK_RECOVERY, S_ATTACK_DIR_RECOV: begin
                    if (cnt_q == ((state_q == S_ATTACK_RECOVERY) ? L_AR : L_DR)) begin
                        state_d = move_state;
                        cnt_d   = is_attack_state(move_state) ? 5'd1 : 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    assign state         = state_q;
    assign hitbox_active = (state_q == S_ATTACK_ACTIVE) || (state_q == S_ATTACK_DIR_ACTIVE);
    assign attack_busy   = is_attack_state(state_q);

endmodule

// File: tb/tb_char_state_handler.sv
// Bench for char_state_handler: directed scenarios plus random button traffic,
// checked against a frame-schedule reference model.
module tb_char_state_handler;

    localparam int NA_S = 5, NA_A = 2, NA_R = 16;
    localparam int DA_S = 4, DA_A = 3, DA_R = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
    logic [3:0] state;
    logic       hitbox_active, attack_busy;

    int checks = 0;
    int errors = 0;

    // reference model: current state plus a queue of scheduled future frames
    int m_state = 0;
    int m_prev  = 0;
    int sched_q[$];

    char_state_handler dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .state         (state),
        .hitbox_active (hitbox_active),
        .attack_busy   (attack_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_n(input int code, input int n);
        for (int i = 0; i < n; i++) sched_q.push_back(code);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_prev  = 0;
        sched_q.delete();
    endtask

    task automatic model_tick(input bit l, input bit r, input bit a);
        bit press;
        press  = a && (m_prev == 0);
        m_prev = a;
        if (sched_q.size() > 0) begin
            m_state = sched_q.pop_front();
        end else if (m_state > 8) begin
            m_state = 0;
        end else begin
            if (press && (l != r))      m_state = 6;
            else if (press)             m_state = 3;
            else if (l && !r)           m_state = 1;
            else if (r && !l)           m_state = 2;
            else                        m_state = 0;
            if (m_state == 3) begin
                push_n(3, NA_S - 1); push_n(4, NA_A); push_n(5, NA_R);
            end else if (m_state == 6) begin
                push_n(6, DA_S - 1); push_n(7, DA_A); push_n(8, DA_R);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"}, 8'(state), 8'(m_state));
        check({tag, ".hitbox"}, 8'(hitbox_active), 8'((m_state == 4) || (m_state == 7)));
        check({tag, ".busy"}, 8'(attack_busy), 8'((m_state >= 3) && (m_state <= 8)));
    endtask

    // starts and ends just after a negedge
    task automatic do_tick(input bit l, input bit r, input bit a, input string tag);
        btn_left = l; btn_right = r; btn_attack = a;
        frame_tick = 1'b1;
        @(posedge clk);
        model_tick(l, r, a);
        @(negedge clk);
        frame_tick = 1'b0;
        check_outputs(tag);
    endtask

    task automatic quiet_clks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            btn_left   = 1'($urandom_range(0, 1));
            btn_right  = 1'($urandom_range(0, 1));
            btn_attack = 1'($urandom_range(0, 1));
            frame_tick = 1'b0;
            @(negedge clk);
            check_outputs(tag);
        end
    endtask

    initial begin
        int busy_cnt, hit_cnt;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // movement
        for (int i = 0; i < 3; i++) do_tick(0, 1, 0, "hold_right");
        check("right_held", 8'(state), 8'd2);
        do_tick(0, 0, 0, "release_right");
        check("right_released", 8'(state), 8'd0);
        for (int i = 0; i < 3; i++) do_tick(1, 1, 0, "both_held");
        check("both_idle", 8'(state), 8'd0);

        // neutral tap: count busy and hitbox frames
        busy_cnt = 0; hit_cnt = 0;
        do_tick(0, 0, 1, "tap");
        busy_cnt += int'(attack_busy); hit_cnt += int'(hitbox_active);
        for (int i = 0; i < 29; i++) begin
            do_tick(0, 0, 0, "neutral_seq");
            busy_cnt += int'(attack_busy); hit_cnt += int'(hitbox_active);
        end
        check("neutral_busy_frames", 8'(busy_cnt), 8'(NA_S + NA_A + NA_R));
        check("neutral_hit_frames", 8'(hit_cnt), 8'(NA_A));
        check("neutral_end", 8'(state), 8'd0);

        // directional attack with left held through recovery
        do_tick(1, 0, 0, "left");
        busy_cnt = 0; hit_cnt = 0;
        do_tick(1, 0, 1, "dir_press");
        check("dir_start", 8'(state), 8'd6);
        busy_cnt += int'(attack_busy); hit_cnt += int'(hitbox_active);
        for (int i = 0; i < DA_S + DA_A + DA_R - 1; i++) begin
            do_tick(1, 0, 0, "dir_seq");
            busy_cnt += int'(attack_busy); hit_cnt += int'(hitbox_active);
        end
        check("dir_busy_frames", 8'(busy_cnt), 8'(DA_S + DA_A + DA_R));
        check("dir_hit_frames", 8'(hit_cnt), 8'(DA_A));
        do_tick(1, 0, 0, "dir_exit");
        check("dir_exit_left", 8'(state), 8'd1);
        do_tick(0, 0, 0, "idle");

        // held attack triggers only once
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            do_tick(0, 0, 1, "attack_held");
            busy_cnt += int'(attack_busy);
        end
        check("held_single_attack", 8'(busy_cnt), 8'(NA_S + NA_A + NA_R));
        check("held_end_idle", 8'(state), 8'd0);
        do_tick(0, 0, 0, "release");
        do_tick(0, 0, 1, "repress");
        check("repress_start", 8'(state), 8'd3);

        // no movement between ticks, mid-attack
        do_tick(0, 0, 0, "pre_quiet");
        quiet_clks(100, "quiet");
        check("quiet_state", 8'(state), 8'd3);
        for (int i = 0; i < 25; i++) do_tick(0, 0, 0, "post_quiet");

        // reset asynchronously while in the active phase
        do_tick(0, 0, 1, "rst_tap");
        for (int i = 0; i < NA_S; i++) do_tick(0, 0, 0, "to_active");
        check("reached_active", 8'(state), 8'd4);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_state", 8'(state), 8'd0);
        check("async_rst_hitbox", 8'(hitbox_active), 8'd0);
        check("async_rst_busy", 8'(attack_busy), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("after_rst");

        // illegal code recovery
        dut.state_q = 4'd12;
        m_state = 12;
        @(negedge clk);
        check("illegal_held", 8'(state), 8'd12);
        do_tick(0, 1, 0, "illegal_exit");
        check("illegal_to_idle", 8'(state), 8'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                quiet_clks($urandom_range(1, 4), "rand_quiet");
            end else begin
                do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
